// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: stage state encoding, drop-counter width and
// a saturating-add helper used by the drop counter.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int DROP_CNT_W = 8;

  // a + b, clamped at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_add(
    input logic [DROP_CNT_W-1:0] a,
    input logic [1:0]            b
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
    return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: adds inc (0..3) when en is high, sticks at the
// maximum value. Updates on the falling edge of clk like the rest of the stage.
// Ports:
//   clk  - clock (falling edge active)
//   rst  - synchronous active-low reset, clears the count
//   en   - add inc this cycle
//   inc  - amount to add
//   cnt  - current saturated count
module pipe_sat_counter
  import pipe_skid_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            inc,
  output logic [DROP_CNT_W-1:0] cnt
);

  always_ff @(negedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sat_add(cnt, inc);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with an optional skid entry. With SKID=1 it holds
// up to two entries and in_ready comes straight from the state register; with
// SKID=0 it is a single register whose in_ready also looks at out_ready.
// flush empties the stage (counting discarded entries), hold freezes it.
//
// Ports:
//   clk       - clock, all state changes on the falling edge
//   rst       - synchronous active-low reset
//   flush     - drop everything held plus this cycle's offered input
//   hold      - freeze: no transfers, outputs keep presenting
//   in_valid  / in_data  / in_ready  - upstream handshake
//   out_valid / out_data / out_ready - downstream handshake
//   count     - entries held (0..2)
//   drop_cnt  - saturating count of entries discarded by flush
//
// state    | meaning
// ST_EMPTY | nothing held, out_data = BUBBLE
// ST_ONE   | main entry valid
// ST_FULL  | main + skid valid (SKID=1 only), input blocked
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  hold,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [1:0]            count,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // SKID=0 is the one place out_ready reaches in_ready combinationally: a
  // single register can refill in the same cycle it drains.
  always_comb begin
    if (SKID) begin
      in_ready = (state_q != ST_FULL);
    end else begin
      in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = (state_q == ST_FULL) ? 2'd2 :
                     (state_q == ST_ONE)  ? 2'd1 : 2'd0;

  assign in_xfer  = in_valid  & in_ready  & ~hold & ~flush;
  assign out_xfer = out_valid & out_ready & ~hold & ~flush;

  // Registers that lose their entry are reloaded with BUBBLE so out_data
  // needs no output mux.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end else if (in_xfer && SKID) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Only entries actually held are counted; the offered input is not.
  pipe_sat_counter u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush),
    .inc (count),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int              W    = 16;
  localparam logic [W-1:0]    BUB1 = 16'hBEEF;
  localparam logic [W-1:0]    BUB0 = 16'h0013;

  logic         clk = 1'b0;
  logic         rst_n, flush, hold, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   count1;
  logic [7:0]   drop1;

  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   count0;
  logic [7:0]   drop0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB1), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst_n), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
    .count(count1), .drop_cnt(drop1)
  );

  pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst_n), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
    .count(count0), .drop_cnt(drop0)
  );

  typedef struct {
    logic         rst_n, flush, hold, iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         ov;
    logic [W-1:0] od;
    logic [1:0]   cnt;
    logic         ir;
    logic [7:0]   drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic h, logic iv, logic [W-1:0] id,
                              logic ordy, logic ov, logic [W-1:0] od, logic [1:0] cnt,
                              logic ir, logic [7:0] drop);
    vec_t v;
    v.rst_n = r; v.flush = f; v.hold = h; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic h, input logic iv,
                       input logic [W-1:0] id, input logic ordy);
    rst_n = r; flush = f; hold = h; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  // State changes on the falling edge; look at outputs shortly after it.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    //          rst f h iv id       ordy ov od       cnt ir drop
    vecs.push_back(mk(0, 0, 0, 1, 16'h1234, 0, 0, BUB1,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, BUB1,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000A, 0, 1, 16'h000A, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000B, 0, 1, 16'h000A, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000C, 0, 1, 16'h000A, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000C, 1, 1, 16'h000B, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h000C, 1, 1, 16'h000C, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, BUB1,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0055, 0, 1, 16'h0055, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 16'h0066, 1, 1, 16'h0055, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 16'h0066, 1, 1, 16'h0055, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 16'h0066, 1, 1, 16'h0055, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, BUB1,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0077, 0, 1, 16'h0077, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0088, 0, 1, 16'h0077, 2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 16'h0088, 1, 1, 16'h0077, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 16'h0099, 1, 0, BUB1,    0, 1, 2));
    vecs.push_back(mk(1, 1, 0, 1, 16'h00AA, 0, 0, BUB1,    0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 1, 16'h00AB, 0, 1, 16'h00AB, 1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 0, BUB1,    0, 1, 3));
    vecs.push_back(mk(1, 0, 0, 1, 16'h00CC, 0, 1, 16'h00CC, 1, 1, 3));
    vecs.push_back(mk(1, 0, 0, 1, 16'h00CD, 0, 1, 16'h00CC, 2, 0, 3));
    vecs.push_back(mk(0, 1, 1, 1, 16'h00CE, 1, 0, BUB1,    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, BUB1,    0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].hold, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid1), 32'(vecs[i].ov));
      chk($sformatf("vec%0d out_data", i),  32'(out_data1),  32'(vecs[i].od));
      chk($sformatf("vec%0d count", i),     32'(count1),     32'(vecs[i].cnt));
      chk($sformatf("vec%0d in_ready", i),  32'(in_ready1),  32'(vecs[i].ir));
      chk($sformatf("vec%0d drop_cnt", i),  32'(drop1),      32'(vecs[i].drop));
    end

    // Streaming: 0x01..0x10 back-to-back, each visible right after acceptance.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, W'(i), 1'b1);
      step();
      chk($sformatf("stream%0d valid", i), 32'(out_valid1), 32'd1);
      chk($sformatf("stream%0d data", i),  32'(out_data1),  32'(i));
      chk($sformatf("stream%0d count", i), 32'(count1),     32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    chk("stream drain valid", 32'(out_valid1), 32'd0);
    chk("stream drain data",  32'(out_data1),  32'(BUB1));

    // Drop counter saturation: fill to two entries, flush with hold, repeat.
    do_reset();
    for (int k = 1; k <= 130; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, W'(k), 1'b0);
      step();
      step();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
      step();
      if (k == 1 || k == 127 || k == 128 || k == 130) begin
        chk($sformatf("sat k=%0d drop_cnt", k), 32'(drop1), 32'((2 * k > 255) ? 255 : 2 * k));
        chk($sformatf("sat k=%0d count", k), 32'(count1), 32'd0);
      end
    end

    // Single-entry variant: one transfer per cycle, blocks when downstream stalls.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, W'(16'h0020 + i), 1'b1);
      step();
      chk($sformatf("skid0 stream%0d data", i), 32'(out_data0), 32'(16'h0020 + i));
      chk($sformatf("skid0 stream%0d ready", i), 32'(in_ready0), 32'd1);
      chk($sformatf("skid0 stream%0d count", i), 32'(count0), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0);
    #1;
    chk("skid0 stall in_ready", 32'(in_ready0), 32'd0);
    step();
    chk("skid0 stall data", 32'(out_data0), 32'h0027);
    chk("skid0 stall ready", 32'(in_ready0), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("skid0 release in_ready", 32'(in_ready0), 32'd1);
    step();
    chk("skid0 refill data", 32'(out_data0), 32'h0030);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    chk("skid0 empty valid", 32'(out_valid0), 32'd0);
    chk("skid0 empty data", 32'(out_data0), 32'(BUB0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
